// File: rtl/mlfpga_pkg.sv
// Shared scaler/collector constants.
// Default widths and row geometry.
package mlfpga_pkg;
    localparam int DATA_WIDTH  = 8;
    localparam int INDEX_WIDTH = DATA_WIDTH + 2;
    localparam int CELL_AMOUNT = 2;
    localparam int ROW_WIDTH   = DATA_WIDTH * CELL_AMOUNT;

    function automatic int cnt_width(input int cells);
        return (cells > 1) ? $clog2(cells) : 1;
    endfunction
endpackage

// File: rtl/scaled_row_collector_if.sv
// Indexed element input plus row stream output
// of the scaled row collector.
interface scaled_row_collector_if
    import mlfpga_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int IW = INDEX_WIDTH,
    parameter int CA = CELL_AMOUNT
) ();
    logic [IW-1:0]    input_index;
    logic [DW-1:0]    input_value;
    logic             input_enable;
    logic [DW*CA-1:0] output_data;
    logic             output_valid;
    logic             output_ready;
    logic             overflow;
    logic             index_error;

    modport slave (
        input  input_index,
        input  input_value,
        input  input_enable,
        input  output_ready,
        output output_data,
        output output_valid,
        output overflow,
        output index_error
    );

    modport master (
        output input_index,
        output input_value,
        output input_enable,
        output output_ready,
        input  output_data,
        input  output_valid,
        input  overflow,
        input  index_error
    );
endinterface

// File: rtl/scaled_row_collector_row_bank.sv
// One row register with per-lane writes
// and a full flag (set wins over clear).
module row_bank
    import mlfpga_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int CA = CELL_AMOUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CA-1:0]    lane_we_i,
    input  logic [DW-1:0]    data_i,
    input  logic             set_i,
    input  logic             clr_i,
    output logic [DW*CA-1:0] row_o,
    output logic             full_o
);
    logic [DW*CA-1:0] row_q, row_d;
    logic             full_q, full_d;

    always_comb begin
        row_d = row_q;
        for (int l = 0; l < CA; l++) begin
            if (lane_we_i[l]) row_d[l*DW +: DW] = data_i;
        end
        full_d = full_q;
        if (set_i)      full_d = 1'b1;
        else if (clr_i) full_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            full_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            full_q <= full_d;
        end
    end

    assign row_o  = row_q;
    assign full_o = full_q;
endmodule

// File: rtl/scaled_row_collector.sv
// Packs CELL_AMOUNT scaled values per row into two
// ping-pong banks and streams full rows out.
module scaled_row_collector
    import mlfpga_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int IW = INDEX_WIDTH,
    parameter int CA = CELL_AMOUNT
) (
    input logic clk,
    input logic rst,
    scaled_row_collector_if.slave bus
);
    localparam int CW = cnt_width(CA);
    localparam int RW = DW * CA;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          overflow_q, overflow_d;
    logic          index_error_q, index_error_d;

    logic [1:0]    full;
    logic [RW-1:0] row [2];
    logic [CA-1:0] lane_we;
    logic [1:0]    set, clr;
    logic          valid, hs, accept, last;

    always_comb begin
        valid  = full[rd_bank_q];
        hs     = valid & bus.output_ready;
        // A bank being drained this cycle may be refilled in the same cycle
        accept = bus.input_enable &
                 (!full[wr_bank_q] |
                  (hs & (wr_bank_q == rd_bank_q)));
        last   = (cnt_q == CW'(CA - 1));

        lane_we = '0;
        if (accept) lane_we[cnt_q] = 1'b1;

        set = '0;
        clr = '0;
        set[wr_bank_q] = accept & last;
        clr[rd_bank_q] = hs;

        cnt_d         = cnt_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q ^ hs;
        overflow_d    = overflow_q;
        index_error_d = index_error_q;

        if (accept) begin
            if (bus.input_index != IW'(cnt_q)) index_error_d = 1'b1;
            if (last) begin
                cnt_d     = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (bus.input_enable) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            overflow_q    <= 1'b0;
            index_error_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            overflow_q    <= overflow_d;
            index_error_q <= index_error_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        row_bank #(
            .DW(DW),
            .CA(CA)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .lane_we_i(wr_bank_q == b[0] ? lane_we : '0),
            .data_i   (bus.input_value),
            .set_i    (set[b]),
            .clr_i    (clr[b]),
            .row_o    (row[b]),
            .full_o   (full[b])
        );
    end

    assign bus.output_data  = row[rd_bank_q];
    assign bus.output_valid = valid;
    assign bus.overflow     = overflow_q;
    assign bus.index_error  = index_error_q;
endmodule

// File: tb/tb_scaled_row_collector.sv
// Directed bench for scaled_row_collector
// with hand-computed rows and status bits.
module tb_scaled_row_collector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scaled_row_collector_if bus ();

    scaled_row_collector dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic drive(input logic en, input logic [9:0] idx,
                         input logic [7:0] val, input logic rdy);
        bus.input_enable = en;
        bus.input_index  = idx;
        bus.input_value  = val;
        bus.output_ready = rdy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(bus.output_valid), 32'd0);
        chk({tag, "_data"},  32'(bus.output_data),  32'h0);
        chk({tag, "_ovf"},   32'(bus.overflow),     32'd0);
        chk({tag, "_ierr"},  32'(bus.index_error),  32'd0);
    endtask

    logic [7:0] prev, cur;

    initial begin
        // 1: reset and a single row
        rst = 1'b1;
        drive(1'b0, 10'd0, 8'd0, 1'b1);
        tick;
        chk_idle("t1_rst");
        rst = 1'b0;
        drive(1'b1, 10'd0, 8'd15, 1'b1);
        tick;
        chk("t1_v_first", 32'(bus.output_valid), 32'd0);
        drive(1'b1, 10'd1, 8'd35, 1'b1);
        tick;
        chk("t1_valid", 32'(bus.output_valid), 32'd1);
        chk("t1_data", 32'(bus.output_data), 32'h230F);
        drive(1'b0, 10'd0, 8'd0, 1'b1);
        tick;
        chk("t1_v_after", 32'(bus.output_valid), 32'd0);

        // 2: stall with two rows held, then drop one element
        drive(1'b1, 10'd0, 8'd10, 1'b0); tick;
        drive(1'b1, 10'd1, 8'd25, 1'b0); tick;
        drive(1'b1, 10'd0, 8'd1, 1'b0);  tick;
        drive(1'b1, 10'd1, 8'd2, 1'b0);  tick;
        chk("t2_valid", 32'(bus.output_valid), 32'd1);
        chk("t2_data", 32'(bus.output_data), 32'h190A);
        chk("t2_ovf0", 32'(bus.overflow), 32'd0);
        drive(1'b1, 10'd0, 8'd7, 1'b0);
        tick;
        chk("t2_ovf1", 32'(bus.overflow), 32'd1);
        chk("t2_hold", 32'(bus.output_data), 32'h190A);
        drive(1'b0, 10'd0, 8'd0, 1'b1);
        tick;
        chk("t2_row2_v", 32'(bus.output_valid), 32'd1);
        chk("t2_row2", 32'(bus.output_data), 32'h0201);
        tick;
        chk("t2_empty", 32'(bus.output_valid), 32'd0);
        chk("t2_ierr", 32'(bus.index_error), 32'd0);

        // 3: refill of the draining bank in the handshake cycle
        rst = 1'b1;
        drive(1'b0, 10'd0, 8'd0, 1'b0);
        tick;
        rst = 1'b0;
        drive(1'b1, 10'd0, 8'd1, 1'b0); tick;
        drive(1'b1, 10'd1, 8'd2, 1'b0); tick;
        drive(1'b1, 10'd0, 8'd8, 1'b0); tick;
        drive(1'b1, 10'd1, 8'd6, 1'b0); tick;
        chk("t3_full", 32'(bus.output_data), 32'h0201);
        drive(1'b1, 10'd0, 8'd9, 1'b1);
        tick;
        chk("t3_ovf", 32'(bus.overflow), 32'd0);
        chk("t3_next", 32'(bus.output_data), 32'h0608);
        chk("t3_next_v", 32'(bus.output_valid), 32'd1);
        drive(1'b1, 10'd1, 8'd4, 1'b0);
        tick;
        chk("t3_hold", 32'(bus.output_data), 32'h0608);
        chk("t3_ovf2", 32'(bus.overflow), 32'd0);
        drive(1'b0, 10'd0, 8'd0, 1'b1);
        tick;
        chk("t3_refill", 32'(bus.output_data), 32'h0409);
        chk("t3_refill_v", 32'(bus.output_valid), 32'd1);
        tick;
        chk("t3_empty", 32'(bus.output_valid), 32'd0);

        // 4: wrong index lands in the counter's lane
        drive(1'b1, 10'd1, 8'd20, 1'b0);
        tick;
        chk("t4_ierr", 32'(bus.index_error), 32'd1);
        chk("t4_v0", 32'(bus.output_valid), 32'd0);
        drive(1'b1, 10'd1, 8'd30, 1'b0);
        tick;
        chk("t4_valid", 32'(bus.output_valid), 32'd1);
        chk("t4_data", 32'(bus.output_data), 32'h1E14);
        drive(1'b0, 10'd0, 8'd0, 1'b1);
        tick;
        chk("t4_empty", 32'(bus.output_valid), 32'd0);
        chk("t4_sticky", 32'(bus.index_error), 32'd1);

        // 5: reset mid-row discards the partial row
        drive(1'b1, 10'd0, 8'd50, 1'b0);
        tick;
        rst = 1'b1;
        drive(1'b0, 10'd0, 8'd0, 1'b0);
        tick;
        chk_idle("t5_rst");
        rst = 1'b0;
        drive(1'b1, 10'd0, 8'd1, 1'b1);
        tick;
        chk("t5_v0", 32'(bus.output_valid), 32'd0);
        drive(1'b1, 10'd1, 8'd2, 1'b1);
        tick;
        chk("t5_valid", 32'(bus.output_valid), 32'd1);
        chk("t5_data", 32'(bus.output_data), 32'h0201);
        chk("t5_ierr", 32'(bus.index_error), 32'd0);
        drive(1'b0, 10'd0, 8'd0, 1'b1);
        tick;
        chk("t5_empty", 32'(bus.output_valid), 32'd0);

        // 6: streaming with ready held high
        prev = 8'd0;
        for (int i = 0; i < 20; i++) begin
            cur = 8'(i * 3 + 1);
            drive(1'b1, 10'(i % 2), cur, 1'b1);
            tick;
            if (i % 2 == 1) begin
                chk($sformatf("t6_v%0d", i),
                    32'(bus.output_valid), 32'd1);
                chk($sformatf("t6_d%0d", i),
                    32'(bus.output_data), 32'({cur, prev}));
            end else if (i > 0) begin
                chk($sformatf("t6_gap%0d", i),
                    32'(bus.output_valid), 32'd0);
            end
            prev = cur;
        end
        drive(1'b0, 10'd0, 8'd0, 1'b1);
        tick;
        chk("t6_end", 32'(bus.output_valid), 32'd0);
        chk("t6_ovf", 32'(bus.overflow), 32'd0);
        chk("t6_ierr", 32'(bus.index_error), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
